// File: rtl/strategy_feed_scheduler_pkg.sv
// Shared types and constants for the strategy feed scheduler.
// Stock count and ID width are fixed at 4 and 2 bits.
package strategy_feed_scheduler_pkg;

  localparam int NUM_STOCKS = 4;
  localparam int ID_W       = 2;
  localparam int PRICE_W    = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EMIT  = 2'd3
  } state_t;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef struct packed {
    logic               side;
    logic [ID_W-1:0]    stock_id;
    logic [PRICE_W-1:0] price;
  } order_t;

  function automatic logic [2:0] count_ones4(input logic [3:0] v);
    count_ones4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr,
// wrapping 3 -> 0. The pointer register lives in the parent.
module rr_arbiter_4
  import strategy_feed_scheduler_pkg::*;
(
  input  logic [3:0]      req,
  input  logic [ID_W-1:0] ptr,
  output logic            grant_valid,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr;
    idx         = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/strategy_feed_scheduler.sv
// Conflating per-stock price slots, round-robin issue to the shared momentum
// engine, and buy/sell order emission on a valid/ready interface.
module strategy_feed_scheduler #(
  parameter int NUM_STOCKS = 4,
  parameter int PRICE_W    = 14,
  parameter int ENGINE_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STOCKS-1:0]         px_valid,
  input  logic [NUM_STOCKS*PRICE_W-1:0] px_price,
  output logic                          eng_enable,
  output logic [1:0]                    eng_stock_id,
  output logic [PRICE_W-1:0]            eng_price,
  input  logic                          eng_buy,
  input  logic                          eng_sell,
  output logic                          ord_valid,
  input  logic                          ord_ready,
  output logic                          ord_side,
  output logic [1:0]                    ord_stock_id,
  output logic [PRICE_W-1:0]            ord_price,
  output logic                          busy,
  output logic [CNT_W-1:0]              conflate_cnt,
  output logic                          proto_err
);
  import strategy_feed_scheduler_pkg::*;

  state_t                             state, state_nxt;
  logic [NUM_STOCKS-1:0]              pending;
  logic [NUM_STOCKS-1:0][PRICE_W-1:0] slot_price;
  logic [1:0]                         rr_ptr;
  logic                               gnt_valid;
  logic [1:0]                         gnt_id;
  logic                               grant;
  logic [ENGINE_LAT-1:0]              wait_pipe;
  logic                               sample;
  logic                               decide;
  logic [NUM_STOCKS-1:0]              conflate_hit;
  logic [CNT_W:0]                     cnt_sum;
  order_t                             ord_q;

  rr_arbiter_4 u_arb (
    .req         (pending),
    .ptr         (rr_ptr),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  assign grant  = (state == ST_IDLE) && gnt_valid;
  // wait_pipe tracks engine latency; its top bit marks the last WAIT cycle.
  assign sample = (state == ST_WAIT) && wait_pipe[ENGINE_LAT-1];
  assign decide = eng_buy | eng_sell;

  // Slots: a strobe always refills; a grant clears only if not refilled.
  for (genvar i = 0; i < NUM_STOCKS; i++) begin : g_slot
    assign conflate_hit[i] = px_valid[i] & pending[i] & ~(grant && gnt_id == 2'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pending[i]    <= 1'b0;
        slot_price[i] <= '0;
      end else if (px_valid[i]) begin
        pending[i]    <= 1'b1;
        slot_price[i] <= px_price[i*PRICE_W +: PRICE_W];
      end else if (grant && gnt_id == 2'(i)) begin
        pending[i]    <= 1'b0;
      end
    end
  end

  assign cnt_sum = {1'b0, conflate_cnt} + (CNT_W+1)'(count_ones4(conflate_hit));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflate_cnt <= '0;
    else     conflate_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    eng_enable = 1'b0;
    ord_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        eng_enable = 1'b1;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT:  if (sample) state_nxt = decide ? ST_EMIT : ST_IDLE;
      ST_EMIT: begin
        ord_valid = 1'b1;
        if (ord_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_pipe <= '0;
    end else begin
      wait_pipe[0] <= (state == ST_ISSUE);
      for (int i = 1; i < ENGINE_LAT; i++) wait_pipe[i] <= wait_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      eng_stock_id <= '0;
      eng_price    <= '0;
    end else if (grant) begin
      rr_ptr       <= gnt_id + 2'd1;
      eng_stock_id <= gnt_id;
      eng_price    <= slot_price[gnt_id];
    end
  end

  // Buy wins a simultaneous buy/sell; the collision is flagged sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_q     <= '0;
      proto_err <= 1'b0;
    end else if (sample) begin
      if (decide) begin
        ord_q.side     <= eng_buy ? SIDE_BUY : SIDE_SELL;
        ord_q.stock_id <= eng_stock_id;
        ord_q.price    <= eng_price;
      end
      if (eng_buy && eng_sell) proto_err <= 1'b1;
    end
  end

  assign ord_side     = ord_q.side;
  assign ord_stock_id = ord_q.stock_id;
  assign ord_price    = ord_q.price;

endmodule

// File: doc/strategy_feed_scheduler.md
Name: strategy_feed_scheduler

Overview:
Sequences the momentum strategy engine across the four tracked stocks. It accepts asynchronous price strobes from four per-stock feeds and holds the latest price per stock in a one-deep conflating slot. A round-robin arbiter issues one price at a time to the shared engine, samples the engine's buy/sell decision, and emits it as an order event on a valid/ready interface. It sits between the market-feed front end and the order path.

Parameters:
NUM_STOCKS, 4, number of feeds; fixed, so the stock ID is 2 bits.
PRICE_W, 14, price width in bits.
ENGINE_LAT, 1, number of cycles from the engine enable cycle to valid buy/sell outputs; legal range 1..4.
CNT_W, 16, width of the conflation counter.

Ports:
clk  in  1  single clock; all logic is rising-edge.
rst  in  1  asynchronous, active-high reset.
px_valid  in  4  per-stock price strobe; bit i belongs to stock i.
px_price  in  56  packed prices; stock i occupies [14i+13:14i].
eng_enable  out  1  one-cycle enable pulse to the strategy engine.
eng_stock_id  out  2  stock ID presented to the engine.
eng_price  out  14  price presented to the engine.
eng_buy  in  1  engine buy decision.
eng_sell  in  1  engine sell decision.
ord_valid  out  1  order event valid.
ord_ready  in  1  downstream accepts the order event.
ord_side  out  1  1 = buy, 0 = sell.
ord_stock_id  out  2  stock ID of the order.
ord_price  out  14  price that produced the decision.
busy  out  1  high whenever the state is not IDLE.
conflate_cnt  out  16  saturating count of overwritten pending prices.
proto_err  out  1  sticky flag: eng_buy and eng_sell were both high at the sample point.

Behaviour:
- Reset: all outputs go to 0 immediately when rst asserts, with no clock edge needed. Pending slots are cleared, the RR pointer goes to 0, and the state goes to IDLE.
- Reset mid-operation: any in-flight issue or order is discarded. No order is emitted after rst releases.
- Slots: each stock has a pending flag and a 14-bit price register.
  - px_valid[i] writes px_price slice i and sets pending[i].
  - If pending[i] is already set and the slot is not being granted in that cycle, conflate_cnt increments, saturating at 0xFFFF.
- Grant: in IDLE with any pending bit set, the round-robin arbiter selects the first pending stock at or after the pointer, wrapping 3 to 0.
  - The granted slot's price is copied to eng_price/eng_stock_id and its pending flag is cleared.
  - The pointer moves to grant+1 mod 4.
- Same-cycle write to the granted stock: a px_valid on the granted stock in the grant cycle refills the slot and sets pending again. This is not counted as conflation.
- FSM states: IDLE, ISSUE, WAIT, EMIT.
  - IDLE -> ISSUE when a grant occurs. eng_stock_id and eng_price are registered at this edge.
  - ISSUE lasts 1 cycle. eng_enable = 1 in this cycle only, then -> WAIT.
  - WAIT lasts ENGINE_LAT cycles. On the last WAIT cycle, eng_buy/eng_sell are sampled.
    - If buy or sell is high -> EMIT; ord_side, ord_stock_id and ord_price are loaded and ord_valid = 1 from the next cycle.
    - If neither is high -> IDLE.
    - If both are high: buy wins and proto_err is set.
  - EMIT: ord_* fields are held stable while ord_valid && !ord_ready. The block goes to IDLE on the cycle ord_valid && ord_ready.
- eng_stock_id and eng_price stay stable from ISSUE through the end of WAIT. eng_enable is 0 in every other state.
- Latency with ENGINE_LAT=1:
  - px_valid at cycle T gives a grant at T+1 (if idle), eng_enable at T+2, and the sample at the end of T+3.
  - ord_valid is high from T+4.
  - An update with no decision takes 3 cycles of occupancy.
- Slots keep accepting strobes in every state, including during EMIT stalls. No new grant is made until the block returns to IDLE.

Decomposition:
- Shared package holds: NUM_STOCKS, ID_W=2, PRICE_W, the FSM state encoding, and the side encoding (SIDE_BUY=1, SIDE_SELL=0).
- One sub-module, rr_arbiter_4. Inputs: 4-bit request, 2-bit pointer. Outputs: grant_valid, 2-bit grant_id. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset: hold rst for 3 cycles with px_valid=4'hF -> every output is 0. After release, the first eng_enable goes to stock 0.
- Single update: px_valid=4'b0010 with price 800, engine model returns buy -> ord_valid at T+4 with ord_side=1, ord_stock_id=1, ord_price=800. busy drops the cycle after the handshake.
- Round-robin: all four valid together with prices 10878, 760, 1260, 2420 and the engine returning neither signal -> eng_enable pulses go to IDs 0,1,2,3, spaced 3 cycles apart. No ord_valid.
- Conflation: while stock 0 is in WAIT, stock 2 receives 1300 then 1310 -> only 1310 is issued and conflate_cnt=1.
- Backpressure: sell decision with ord_ready low for 5 cycles -> ord_* stays stable, no eng_enable pulse occurs, and the handshake on the 6th cycle returns to IDLE.
- Async reset mid-WAIT: pulse rst between clock edges -> outputs clear without a clock edge, and no order follows. Separately, an engine model driving both buy and sell -> ord_side=1 and proto_err=1.
